// File: rtl/ratio_divider_pkg.sv
// Shared types and helpers for the ratio divider and related iterative arithmetic stages.
// div_step performs one restoring-division iteration on a widened remainder.
package ratio_divider_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int FRAC_BITS_DEFAULT = 8;

    // Width of the generic step datapath; callers zero-extend narrower operands into it.
    localparam int STEP_W = 33;

    // Saturation pattern; callers take the low OUT_WIDTH bits.
    localparam logic [63:0] ALL_ONES = '1;

    typedef struct packed {
        logic [STEP_W-1:0] rem;
        logic              q_bit;
    } step_t;

    // Precondition: remainder < divisor, so the shifted value never needs more than STEP_W+1 bits
    // and a set top bit of the difference means the trial subtraction borrowed.
    function automatic step_t div_step(
        input logic [STEP_W-1:0] remainder,
        input logic              dividend_msb,
        input logic [STEP_W-1:0] divisor
    );
        step_t             r;
        logic [STEP_W:0]   shifted;
        logic [STEP_W:0]   diff;
        logic              borrow;
        shifted = {remainder, dividend_msb};
        diff    = shifted - {1'b0, divisor};
        borrow  = diff[STEP_W];
        r.q_bit = ~borrow;
        r.rem   = borrow ? shifted[STEP_W-1:0] : diff[STEP_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/ratio_divider.sv
// Sequential restoring divider: quotient_8_shifted = floor(numerator * 2^FRAC_BITS / denominator).
// One quotient bit per clock; result register holds the last answer for the downstream log stage.
module ratio_divider
    import ratio_divider_pkg::*;
#(
    parameter int NUM_WIDTH = 16,
    parameter int FRAC_BITS = FRAC_BITS_DEFAULT,
    parameter int OUT_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 I_RSTn,
    input  logic                 start,
    input  logic [NUM_WIDTH-1:0] numerator,
    input  logic [NUM_WIDTH-1:0] denominator,
    output logic                 busy,
    output logic                 done,
    output logic                 div_by_zero,
    output logic [OUT_WIDTH-1:0] quotient_8_shifted
);

    localparam int REM_W = NUM_WIDTH + 1;
    localparam int CNT_W = $clog2(OUT_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(OUT_WIDTH - 1);

    generate
        if (OUT_WIDTH != NUM_WIDTH + FRAC_BITS) begin : g_bad_out_width
            $error("ratio_divider: OUT_WIDTH must equal NUM_WIDTH + FRAC_BITS");
        end
        if (REM_W > STEP_W) begin : g_bad_step_width
            $error("ratio_divider: NUM_WIDTH too wide for div_step");
        end
    endgenerate

    state_t                 state;
    logic [OUT_WIDTH-1:0]   dividend;
    logic [NUM_WIDTH-1:0]   divisor;
    logic [REM_W-1:0]       remainder;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   zero_flag;
    step_t                  step;

    // The dividend register doubles as the quotient: each iteration shifts one dividend
    // bit out of the top and one quotient bit in at the bottom.
    always_comb begin
        step = div_step(STEP_W'(remainder), dividend[OUT_WIDTH-1], STEP_W'(divisor));
    end

    generate
        if (STEP_W > REM_W) begin : g_unused_step
            logic unused_step_bits;
            assign unused_step_bits = ^step.rem[STEP_W-1:REM_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!I_RSTn) begin
            state              <= IDLE;
            busy               <= 1'b0;
            done               <= 1'b0;
            div_by_zero        <= 1'b0;
            quotient_8_shifted <= '0;
            dividend           <= '0;
            divisor            <= '0;
            remainder          <= '0;
            bit_cnt            <= '0;
            zero_flag          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        dividend  <= {numerator, {FRAC_BITS{1'b0}}};
                        divisor   <= denominator;
                        remainder <= '0;
                        bit_cnt   <= '0;
                        zero_flag <= (denominator == '0);
                    end
                end
                RUN: begin
                    remainder <= step.rem[REM_W-1:0];
                    dividend  <= {dividend[OUT_WIDTH-2:0], step.q_bit};
                    bit_cnt   <= bit_cnt + 1'b1;
                    // Divide-by-zero still runs all iterations so latency never depends on operands.
                    if (bit_cnt == LAST_ITER) begin
                        state              <= IDLE;
                        busy               <= 1'b0;
                        done               <= 1'b1;
                        div_by_zero        <= zero_flag;
                        quotient_8_shifted <= zero_flag ? ALL_ONES[OUT_WIDTH-1:0]
                                                        : {dividend[OUT_WIDTH-2:0], step.q_bit};
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ratio_divider.sv
// Self-checking bench for ratio_divider: vector table, randomized ops against an arithmetic
// reference, and hand-written handshake and reset sequences.
module tb_ratio_divider;

    localparam int NW = 16;
    localparam int FB = 8;
    localparam int OW = 24;

    logic          clk = 1'b0;
    logic          I_RSTn;
    logic          start;
    logic [NW-1:0] numerator;
    logic [NW-1:0] denominator;
    logic          busy;
    logic          done;
    logic          div_by_zero;
    logic [OW-1:0] quotient_8_shifted;

    int n_cmp  = 0;
    int n_fail = 0;

    // Scoreboard entries are {div_by_zero, quotient}.
    logic [OW:0] exp_q[$];

    typedef struct {
        logic [NW-1:0] num;
        logic [NW-1:0] den;
        logic [OW-1:0] q;
        logic          dz;
        string         name;
    } vec_t;

    vec_t vecs[10];

    ratio_divider #(
        .NUM_WIDTH(NW),
        .FRAC_BITS(FB),
        .OUT_WIDTH(OW)
    ) dut (
        .clk               (clk),
        .I_RSTn            (I_RSTn),
        .start             (start),
        .numerator         (numerator),
        .denominator       (denominator),
        .busy              (busy),
        .done              (done),
        .div_by_zero       (div_by_zero),
        .quotient_8_shifted(quotient_8_shifted)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [OW:0] model(input logic [NW-1:0] n, input logic [NW-1:0] d);
        longint unsigned scaled;
        if (d == 0) return {1'b1, {OW{1'b1}}};
        scaled = (longint'(n) * (longint'(1) << FB)) / longint'(d);
        return {1'b0, OW'(scaled)};
    endfunction

    // Driver: one op, operands scrambled right after acceptance.
    task automatic run_op(input logic [NW-1:0] n, input logic [NW-1:0] d,
                          input logic [OW-1:0] eq, input logic edz, input string name);
        int          lat;
        int          busy_cycles;
        logic [OW:0] exp;
        @(negedge clk);
        numerator   = n;
        denominator = d;
        start       = 1'b1;
        exp_q.push_back({edz, eq});
        @(posedge clk);
        #1;
        start       = 1'b0;
        numerator   = NW'($urandom);
        denominator = NW'($urandom);
        lat         = 0;
        busy_cycles = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) busy_cycles++;
        end while (!done && lat < 40);
        check({name, " latency"}, 32'(lat), 32'd25);
        check({name, " busy cycles"}, 32'(busy_cycles), 32'd24);
        exp = exp_q.pop_front();
        check({name, " quotient"}, 32'(quotient_8_shifted), 32'(exp[OW-1:0]));
        check({name, " div_by_zero"}, 32'(div_by_zero), 32'(exp[OW]));
        @(negedge clk);
        check({name, " done width"}, 32'(done), 32'd0);
    endtask

    initial begin
        int          t1;
        int          c2;
        int          done_seen;
        logic [NW-1:0] rn;
        logic [NW-1:0] rd;
        logic [OW:0]   m;

        vecs[0] = '{16'd200,   16'd100,   24'h000200, 1'b0, "int_200_100"};
        vecs[1] = '{16'd1,     16'd3,     24'h000055, 1'b0, "frac_1_3"};
        vecs[2] = '{16'd3,     16'd2,     24'h000180, 1'b0, "frac_3_2"};
        vecs[3] = '{16'd65535, 16'd1,     24'hFFFF00, 1'b0, "full_scale"};
        vecs[4] = '{16'd0,     16'd7,     24'h000000, 1'b0, "zero_num"};
        vecs[5] = '{16'd5,     16'd0,     24'hFFFFFF, 1'b1, "div_zero"};
        vecs[6] = '{16'd10,    16'd5,     24'h000200, 1'b0, "after_dz"};
        vecs[7] = '{16'd100,   16'd200,   24'h000080, 1'b0, "below_one"};
        vecs[8] = '{16'd65535, 16'd65535, 24'h000100, 1'b0, "unity_max"};
        vecs[9] = '{16'd1,     16'd65535, 24'h000000, 1'b0, "tiny"};

        I_RSTn      = 1'b0;
        start       = 1'b0;
        numerator   = '0;
        denominator = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset dz", 32'(div_by_zero), 32'd0);
        check("reset quotient", 32'(quotient_8_shifted), 32'd0);
        I_RSTn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].num, vecs[i].den, vecs[i].q, vecs[i].dz, vecs[i].name);
        end

        for (int i = 0; i < 40; i++) begin
            rn = NW'($urandom);
            if ($urandom_range(0, 3) == 0) rn = NW'($urandom_range(0, 20));
            case ($urandom_range(0, 9))
                0:       rd = '0;
                1, 2, 3: rd = NW'($urandom_range(1, 15));
                default: rd = NW'($urandom);
            endcase
            m = model(rn, rd);
            run_op(rn, rd, m[OW-1:0], m[OW], "random");
        end

        // Back-to-back with start held high and operands changed mid-run
        @(negedge clk);
        numerator   = 16'd200;
        denominator = 16'd100;
        start       = 1'b1;
        @(posedge clk);
        #1;
        numerator   = 16'd3;
        denominator = 16'd2;
        t1 = 0;
        do begin
            @(negedge clk);
            t1++;
        end while (!done && t1 < 40);
        check("b2b first latency", 32'(t1), 32'd25);
        check("b2b first quotient", 32'(quotient_8_shifted), 32'h000200);
        check("b2b busy in done cycle", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("b2b done width", 32'(done), 32'd0);
        check("b2b second accepted", 32'(busy), 32'd1);
        c2 = 0;
        do begin
            @(negedge clk);
            c2++;
        end while (!done && c2 < 40);
        check("b2b done spacing", 32'(c2 + 1), 32'd25);
        check("b2b second quotient", 32'(quotient_8_shifted), 32'h000180);
        check("b2b second dz", 32'(div_by_zero), 32'd0);

        // Reset asserted for one clock at iteration 10
        @(negedge clk);
        numerator   = 16'd200;
        denominator = 16'd100;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        I_RSTn = 1'b0;
        @(posedge clk);
        #1;
        I_RSTn = 1'b1;
        @(negedge clk);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst quotient", 32'(quotient_8_shifted), 32'd0);
        check("midrst dz", 32'(div_by_zero), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("midrst no done", 32'(done_seen), 32'd0);
        run_op(16'd200, 16'd100, 24'h000200, 1'b0, "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ratio_divider.md
Name: ratio_divider

Overview:
- Sequential unsigned fixed-point divider that forms ratio = numerator / denominator in 16.8 format (value × 256).
- Sits directly upstream of the natural-log stage in discrete RC charge/discharge paths. Example: ln(Vs / (Vs − Vc)) for time-constant computation.
- Restoring algorithm, one quotient bit per clock, start/busy/done handshake.
- Output register holds the last result so the downstream log stage can sample it continuously.

Parameters:
- NUM_WIDTH, 16, width of numerator and denominator (unsigned).
- FRAC_BITS, 8, fractional bits in the quotient; the dividend is numerator << FRAC_BITS.
- OUT_WIDTH, 24, quotient width. Must equal NUM_WIDTH + FRAC_BITS; elaboration-time assertion.

Ports:
- clk  in  1  system clock
- I_RSTn  in  1  synchronous active-low reset, sampled on rising clk
- start  in  1  request a division; sampled only in IDLE
- numerator  in  NUM_WIDTH  unsigned dividend (integer)
- denominator  in  NUM_WIDTH  unsigned divisor (integer)
- busy  out  1  high while an operation is in progress
- done  out  1  single-cycle pulse: new result valid
- div_by_zero  out  1  flag for last result; updated with done
- quotient_8_shifted  out  OUT_WIDTH  floor(numerator × 2^FRAC_BITS / denominator), held until next done

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous, active-low (I_RSTn sampled on the rising edge of clk).
  - Reset values: state=IDLE, busy=0, done=0, div_by_zero=0, quotient_8_shifted=0, internal counter/remainder/operands=0.
- States:
  - IDLE → RUN: on start=1. Latch dividend = {numerator, FRAC_BITS'b0}, divisor = denominator, remainder=0, bit counter=0, zero flag = (denominator==0).
  - RUN: each clock shifts the dividend MSB into the remainder and trial-subtracts the divisor. If there is no borrow, keep the difference and set the quotient bit to 1; otherwise restore and set it to 0.
  - The counter increments each clock. On the OUT_WIDTH-th RUN clock, write quotient_8_shifted and div_by_zero, pulse done, and return to IDLE.
- Latency:
  - start sampled at edge E0; iterations at edges E1..E24; done=1 during exactly the one cycle following E24.
  - Fixed 25 clocks from accepting edge to done, independent of operand values (including divide-by-zero).
- busy: 1 in every cycle where state=RUN; 0 in the done cycle.
- Back-to-back: start may be asserted in the done cycle and is accepted, giving a 25-clock throughput.
- start while busy: ignored; operands are not re-latched, no queuing.
- Divide-by-zero: the iterations still run for timing uniformity. The result is forced to all ones (24'hFFFFFF) and div_by_zero=1 with done.
- Remainder register width: NUM_WIDTH+1 bits so the trial subtraction cannot overflow.
- numerator=0, denominator≠0: result 0, div_by_zero=0.
- Quotient < 1.0 (numerator < denominator) is a legal output. Clamping to the log domain is the consumer's job.
- Reset mid-operation: the next cycle is IDLE with all outputs at reset values. No done is produced for the aborted operation, and quotient_8_shifted is cleared.
- Operand ports may change after acceptance without affecting the result.

Decomposition:
- Shared package:
  - state enum {IDLE, RUN}
  - FRAC_BITS_DEFAULT = 8
  - ALL_ONES saturation constant
  - a pure function div_step(remainder, dividend_msb, divisor), returning {new_remainder, q_bit}, reusable by other iterative arithmetic stages
- No sub-module: a single module holding the FSM, counter and datapath is the natural size.

Test Plan:
- Integer ratio: numerator=200, denominator=100, start pulse → done exactly 25 clocks after the accepting edge, quotient_8_shifted=24'h000200, div_by_zero=0, busy high 24 cycles.
- Fraction and truncation: numerator=1, denominator=3 → quotient_8_shifted=24'h000055 (85); then numerator=3, denominator=2 → 24'h000180.
- Full scale: numerator=65535, denominator=1 → 24'hFFFF00; then numerator=0, denominator=7 → 24'h000000.
- Divide-by-zero: numerator=5, denominator=0 → after 25 clocks quotient_8_shifted=24'hFFFFFF, div_by_zero=1. Next op (10/5) clears the flag and yields 24'h000200.
- Handshake:
  - start held high continuously with operands changed mid-run → only the latched operands are used; a new op is accepted in the done cycle.
  - Done pulses are spaced exactly 25 clocks apart and each is one cycle wide.
- Reset mid-run: assert I_RSTn=0 for one clock at iteration 10 → the next cycle shows busy=0, done=0, quotient=0. No done follows, and a subsequent 200/100 op returns 24'h000200.
